mips_pipeline_core: RTL and testbench

Five-stage pipelined 32-bit MIPS integer core (IF, ID, EX, MEM, WB) with private instruction memory, register file and data memory. It resolves data hazards by forwarding plus a load-use stall, and control hazards by flushing. It is the top of the processor subsystem: its only ports are clock, reset and a halt input, and benches observe state through fixed hierarchical names.

---
 rtl/mips_pipeline_core_pkg.sv | 72 +++++++
 rtl/mips_pipeline_core_hazard.sv | 48 ++++
 rtl/mips_pipeline_core_mem.sv | 57 +++++
 rtl/mips_pipeline_core.sv | 224 ++++++++++++++++++++++
 tb/tb_mips_pipeline_core.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mips_pipeline_core_pkg.sv
// Shared ISA constants, ALU/forward encodings and pipeline-register layouts for the 5-stage MIPS core.
// Pure declarations: no latency, no flow control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
  } mem_wb_t;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: alu = a + b;
      ALU_SUB: alu = a - b;
      ALU_AND: alu = a & b;
      ALU_OR:  alu = a | b;
      ALU_SLT: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_pipeline_core_hazard.sv
// Forward selects for EX operands, load-use stall and flush/redirect decisions; purely combinational.
// Taken beq overrides a stall, and a stall overrides a j in ID.
module hazard_unit
  import mips_pkg::*;
(
  input  logic       i_id_uses_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_dest,
  input  logic [4:0] i_ex_rs,
  input  logic [4:0] i_ex_rt,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_dest,
  input  logic       i_wb_reg_write,
  input  logic [4:0] i_wb_dest,
  input  logic       i_br_taken,
  input  logic       i_id_jump,
  output fwd_sel_e   o_fwd_a,
  output fwd_sel_e   o_fwd_b,
  output logic       o_stall,
  output logic       o_take_jump,
  output logic       o_flush_ifid,
  output logic       o_flush_idex
);
  logic w_load_use;
  logic w_mem_ok;
  logic w_wb_ok;

  assign w_mem_ok = i_mem_reg_write && (i_mem_dest != 5'd0);
  assign w_wb_ok  = i_wb_reg_write && (i_wb_dest != 5'd0);

  always_comb begin
    o_fwd_a = FWD_NONE;
    o_fwd_b = FWD_NONE;
    if (w_mem_ok && i_mem_dest == i_ex_rs)     o_fwd_a = FWD_MEM;
    else if (w_wb_ok && i_wb_dest == i_ex_rs)  o_fwd_a = FWD_WB;
    if (w_mem_ok && i_mem_dest == i_ex_rt)     o_fwd_b = FWD_MEM;
    else if (w_wb_ok && i_wb_dest == i_ex_rt)  o_fwd_b = FWD_WB;
  end

  assign w_load_use   = i_ex_mem_read &&
                        ((i_ex_dest == i_id_rs) || (i_id_uses_rt && i_ex_dest == i_id_rt));
  assign o_stall      = w_load_use && !i_br_taken;
  assign o_take_jump  = i_id_jump && !i_br_taken && !w_load_use;
  assign o_flush_ifid = i_br_taken || o_take_jump;
  assign o_flush_idex = i_br_taken;
endmodule

// File: rtl/mips_pipeline_core_mem.sv
// Leaf storage for the core: instruction ROM, 2R1W register file with write-through, big-endian byte data memory.
// Reads are combinational; writes land on the rising edge.
module mips_imem #(
  parameter int WORDS = 256
) (
  input  logic [$clog2(WORDS)-1:0] i_addr,
  output logic [31:0]              o_data
);
  logic [31:0] memory [WORDS];

  assign o_data = memory[i_addr];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] Registers [32];

  always_ff @(posedge clk) begin
    if (i_we && i_wa != 5'd0) Registers[i_wa] <= i_wd;
  end

  // A read of the register being written this cycle sees the new value.
  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : (i_we && i_wa == i_ra1) ? i_wd : Registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : (i_we && i_wa == i_ra2) ? i_wd : Registers[i_ra2];
endmodule

module mips_dmem #(
  parameter int BYTES = 256
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(BYTES)-3:0]   i_waddr,
  input  logic [31:0]                i_wd,
  output logic [31:0]                o_rd
);
  logic [7:0] memory [BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      memory[{i_waddr, 2'b00}] <= i_wd[31:24];
      memory[{i_waddr, 2'b01}] <= i_wd[23:16];
      memory[{i_waddr, 2'b10}] <= i_wd[15:8];
      memory[{i_waddr, 2'b11}] <= i_wd[7:0];
    end
  end

  assign o_rd = {memory[{i_waddr, 2'b00}], memory[{i_waddr, 2'b01}],
                 memory[{i_waddr, 2'b10}], memory[{i_waddr, 2'b11}]};
endmodule

// File: rtl/mips_pipeline_core.sv
// Five-stage MIPS integer core (IF/ID/EX/MEM/WB) with private IM/RF/DM; 4 cycles fetch-to-writeback, CPI 1.
// finish freezes every state element; load-use costs 1 bubble, j 1 cycle, taken beq 2 cycles.
module mips_pipeline_core
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 256
) (
  input logic clk,
  input logic reset_n,
  input logic finish
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  logic [31:0] pc;
  logic [31:0] OutInstruction;
  logic        outMR, outMW, outWBRegWrite;
  logic [31:0] DataMemoryOut, outReadData2, MemRoute;
  logic [4:0]  outWriteBackfinal;

  if_id_t  r_if_id;
  id_ex_t  r_id_ex, w_id_ex;
  ex_mem_t r_ex_mem, w_ex_mem;
  mem_wb_t r_mem_wb, w_mem_wb;

  logic [31:0] w_pc4, w_jump_target, w_br_target;
  logic [31:0] w_rd1, w_rd2, w_op_a, w_op_b_reg, w_alu_b, w_alu_res;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic        w_id_jump, w_id_uses_rt, w_br_taken;
  logic        w_stall, w_take_jump, w_flush_ifid, w_flush_idex;
  fwd_sel_e    w_fwd_a, w_fwd_b;

  // ---------------- IF ----------------
  mips_imem #(.WORDS(IMEM_WORDS)) IM (
    .i_addr (pc[IAW+1:2]),
    .o_data (OutInstruction)
  );

  assign w_pc4 = pc + 32'd4;

  // ---------------- ID ----------------
  assign w_opcode      = r_if_id.instr[31:26];
  assign w_rs          = r_if_id.instr[25:21];
  assign w_rt          = r_if_id.instr[20:16];
  assign w_rd          = r_if_id.instr[15:11];
  assign w_funct       = r_if_id.instr[5:0];
  assign w_jump_target = {r_if_id.pc4[31:28], r_if_id.instr[25:0], 2'b00};

  mips_regfile RF (
    .clk   (clk),
    .i_we  (r_mem_wb.reg_write && !finish),
    .i_wa  (r_mem_wb.dest),
    .i_wd  (MemRoute),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Unrecognised opcodes/functs leave every control bit clear and flow through as nops.
  always_comb begin
    w_id_ex      = '0;
    w_id_jump    = 1'b0;
    w_id_uses_rt = 1'b0;
    w_id_ex.rs   = w_rs;
    w_id_ex.rt   = w_rt;
    w_id_ex.rd1  = w_rd1;
    w_id_ex.rd2  = w_rd2;
    w_id_ex.imm  = {{16{r_if_id.instr[15]}}, r_if_id.instr[15:0]};
    w_id_ex.pc4  = r_if_id.pc4;
    case (w_opcode)
      OP_RTYPE: begin
        w_id_uses_rt      = 1'b1;
        w_id_ex.dest      = w_rd;
        w_id_ex.reg_write = 1'b1;
        case (w_funct)
          FN_ADD:  w_id_ex.alu_op = ALU_ADD;
          FN_SUB:  w_id_ex.alu_op = ALU_SUB;
          FN_AND:  w_id_ex.alu_op = ALU_AND;
          FN_OR:   w_id_ex.alu_op = ALU_OR;
          FN_SLT:  w_id_ex.alu_op = ALU_SLT;
          default: w_id_ex.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_id_ex.reg_write = 1'b1;
        w_id_ex.alu_src   = 1'b1;
        w_id_ex.dest      = w_rt;
      end
      OP_LW: begin
        w_id_ex.reg_write  = 1'b1;
        w_id_ex.mem_read   = 1'b1;
        w_id_ex.mem_to_reg = 1'b1;
        w_id_ex.alu_src    = 1'b1;
        w_id_ex.dest       = w_rt;
      end
      OP_SW: begin
        w_id_uses_rt      = 1'b1;
        w_id_ex.mem_write = 1'b1;
        w_id_ex.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        w_id_uses_rt    = 1'b1;
        w_id_ex.branch  = 1'b1;
        w_id_ex.alu_op  = ALU_SUB;
      end
      OP_J:    w_id_jump = 1'b1;
      default: ;
    endcase
  end

  hazard_unit u_hazard (
    .i_id_uses_rt    (w_id_uses_rt),
    .i_id_rs         (w_rs),
    .i_id_rt         (w_rt),
    .i_ex_mem_read   (r_id_ex.mem_read),
    .i_ex_dest       (r_id_ex.dest),
    .i_ex_rs         (r_id_ex.rs),
    .i_ex_rt         (r_id_ex.rt),
    .i_mem_reg_write (r_ex_mem.reg_write),
    .i_mem_dest      (r_ex_mem.dest),
    .i_wb_reg_write  (r_mem_wb.reg_write),
    .i_wb_dest       (r_mem_wb.dest),
    .i_br_taken      (w_br_taken),
    .i_id_jump       (w_id_jump),
    .o_fwd_a         (w_fwd_a),
    .o_fwd_b         (w_fwd_b),
    .o_stall         (w_stall),
    .o_take_jump     (w_take_jump),
    .o_flush_ifid    (w_flush_ifid),
    .o_flush_idex    (w_flush_idex)
  );

  // ---------------- EX ----------------
  always_comb begin
    case (w_fwd_a)
      FWD_MEM: w_op_a = r_ex_mem.alu_res;
      FWD_WB:  w_op_a = MemRoute;
      default: w_op_a = r_id_ex.rd1;
    endcase
    case (w_fwd_b)
      FWD_MEM: w_op_b_reg = r_ex_mem.alu_res;
      FWD_WB:  w_op_b_reg = MemRoute;
      default: w_op_b_reg = r_id_ex.rd2;
    endcase
  end

  assign w_alu_b     = r_id_ex.alu_src ? r_id_ex.imm : w_op_b_reg;
  assign w_alu_res   = alu(r_id_ex.alu_op, w_op_a, w_alu_b);
  assign w_br_taken  = r_id_ex.branch && (w_op_a == w_op_b_reg);
  assign w_br_target = r_id_ex.pc4 + {r_id_ex.imm[29:0], 2'b00};

  always_comb begin
    w_ex_mem            = '0;
    w_ex_mem.reg_write  = r_id_ex.reg_write;
    w_ex_mem.mem_read   = r_id_ex.mem_read;
    w_ex_mem.mem_write  = r_id_ex.mem_write;
    w_ex_mem.mem_to_reg = r_id_ex.mem_to_reg;
    w_ex_mem.dest       = r_id_ex.dest;
    w_ex_mem.alu_res    = w_alu_res;
    w_ex_mem.store_data = w_op_b_reg;
  end

  // ---------------- MEM ----------------
  mips_dmem #(.BYTES(DMEM_BYTES)) DM (
    .clk     (clk),
    .i_we    (r_ex_mem.mem_write && !finish),
    .i_waddr (r_ex_mem.alu_res[DAW-1:2]),
    .i_wd    (r_ex_mem.store_data),
    .o_rd    (DataMemoryOut)
  );

  assign outMR        = r_ex_mem.mem_read;
  assign outMW        = r_ex_mem.mem_write;
  assign outReadData2 = r_ex_mem.store_data;

  always_comb begin
    w_mem_wb            = '0;
    w_mem_wb.reg_write  = r_ex_mem.reg_write;
    w_mem_wb.mem_to_reg = r_ex_mem.mem_to_reg;
    w_mem_wb.dest       = r_ex_mem.dest;
    w_mem_wb.alu_res    = r_ex_mem.alu_res;
    w_mem_wb.mem_data   = DataMemoryOut;
  end

  // ---------------- WB ----------------
  assign outWBRegWrite     = r_mem_wb.reg_write;
  assign outWriteBackfinal = r_mem_wb.dest;
  assign MemRoute          = r_mem_wb.mem_to_reg ? r_mem_wb.mem_data : r_mem_wb.alu_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= '0;
      r_if_id  <= '0;
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
    end else if (!finish) begin
      r_ex_mem <= w_ex_mem;
      r_mem_wb <= w_mem_wb;
      if (w_flush_idex) begin
        pc      <= w_br_target;
        r_if_id <= '0;
        r_id_ex <= '0;
      end else if (w_stall) begin
        r_id_ex <= '0;
      end else if (w_take_jump) begin
        pc      <= w_jump_target;
        r_if_id <= '0;
        r_id_ex <= w_id_ex;
      end else begin
        pc      <= w_pc4;
        r_if_id <= '{pc4: w_pc4, instr: OutInstruction};
        r_id_ex <= w_id_ex;
      end
    end
  end

  logic w_unused_flush_ifid;
  assign w_unused_flush_ifid = w_flush_ifid;

endmodule

// File: tb/tb_mips_pipeline_core.sv
// Directed program bench: hand-assembled MIPS code with cycle-exact checks on pipeline observation points.
module tb_mips_pipeline_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic finish = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic squashed_wb = 1'b0;

  always #5 clk = ~clk;

  mips_pipeline_core #(.IMEM_WORDS(256), .DMEM_BYTES(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .finish  (finish)
  );

  logic [31:0] prog [21] = '{
    32'h20080005, // 0  addi $t0,$0,5
    32'h20090007, // 1  addi $t1,$0,7
    32'h01095020, // 2  add  $t2,$t0,$t1
    32'hAC0A0000, // 3  sw   $t2,0($0)
    32'h8C0B0000, // 4  lw   $t3,0($0)
    32'h016B6020, // 5  add  $t4,$t3,$t3
    32'h0800000A, // 6  j    10
    32'h20110077, // 7  addi $s1,$0,0x77  (squashed)
    32'h20110055, // 8  addi $s1 (skipped)
    32'h20110066, // 9  addi $s1 (skipped)
    32'h20150028, // 10 addi $s5,$0,0x28
    32'h11080002, // 11 beq  $t0,$t0,+2
    32'h20120088, // 12 addi $s2 (squashed)
    32'h20120099, // 13 addi $s2 (squashed)
    32'h0128682A, // 14 slt  $t5,$t1,$t0
    32'h01097022, // 15 sub  $t6,$t0,$t1
    32'h20000009, // 16 addi $0,$0,9
    32'h00008020, // 17 add  $s0,$0,$0
    32'h018A9824, // 18 and  $s3,$t4,$t2
    32'h018AA025, // 19 or   $s4,$t4,$t2
    32'h08000014  // 20 j    20
  };

  always @(negedge clk) begin
    if (reset_n && !finish && dut.outWBRegWrite &&
        (dut.outWriteBackfinal == 5'd17 || dut.outWriteBackfinal == 5'd18))
      squashed_wb = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_pc"},   dut.pc, 32'h0);
    check({tag, "_mr"},   {31'd0, dut.outMR}, 32'h0);
    check({tag, "_mw"},   {31'd0, dut.outMW}, 32'h0);
    check({tag, "_wbrw"}, {31'd0, dut.outWBRegWrite}, 32'h0);
    check({tag, "_wbd"},  {27'd0, dut.outWriteBackfinal}, 32'h0);
    check({tag, "_route"}, dut.MemRoute, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dut.IM.memory[i] = 32'h0;
    for (int i = 0; i < 21; i++) dut.IM.memory[i] = prog[i];

    // ---- run 1: full program ----
    tick(2);
    check_reset_outs("rst1");
    check("rst1_fetch", dut.OutInstruction, 32'h20080005);
    reset_n = 1'b1;

    tick(1); // E1
    check("e1_pc", dut.pc, 32'h4);
    check("e1_fetch", dut.OutInstruction, 32'h20090007);
    tick(3); // E4: addi $t0 in WB
    check("e4_wbrw", {31'd0, dut.outWBRegWrite}, 32'h1);
    check("e4_wbd", {27'd0, dut.outWriteBackfinal}, 32'd8);
    check("e4_route", dut.MemRoute, 32'd5);
    tick(2); // E6: add $t2 in WB, sw in MEM, load-use pending
    check("e6_pc", dut.pc, 32'h18);
    check("e6_route_t2", dut.MemRoute, 32'd12);
    check("e6_mw", {31'd0, dut.outMW}, 32'h1);
    check("e6_sw_data", dut.outReadData2, 32'd12);
    tick(1); // E7: stall holds pc
    check("e7_pc_hold", dut.pc, 32'h18);
    check("e7_t2", dut.RF.Registers[10], 32'd12);
    check("e7_mr", {31'd0, dut.outMR}, 32'h1);
    check("e7_lw_data", dut.DataMemoryOut, 32'h0000000C);
    check("e7_dm0", {24'd0, dut.DM.memory[0]}, 32'h00);
    check("e7_dm3", {24'd0, dut.DM.memory[3]}, 32'h0C);
    tick(1); // E8
    check("e8_pc", dut.pc, 32'h1C);
    tick(1); // E9: j taken
    check("e9_pc_jump", dut.pc, 32'h28);
    tick(4); // E13: beq taken
    check("e13_pc_beq", dut.pc, 32'h38);
    check("e13_fetch", dut.OutInstruction, 32'h0128682A);
    tick(27);
    check("t0", dut.RF.Registers[8], 32'd5);
    check("t1", dut.RF.Registers[9], 32'd7);
    check("t3", dut.RF.Registers[11], 32'd12);
    check("t4", dut.RF.Registers[12], 32'd24);
    check("t5_slt", dut.RF.Registers[13], 32'd0);
    check("t6_sub", dut.RF.Registers[14], 32'hFFFFFFFE);
    check("s0_zero_src", dut.RF.Registers[16], 32'd0);
    check("s3_and", dut.RF.Registers[19], 32'd8);
    check("s4_or", dut.RF.Registers[20], 32'h1C);
    check("s5_jtarget", dut.RF.Registers[21], 32'h28);
    check("no_squashed_wb", {31'd0, squashed_wb}, 32'h0);

    // ---- run 2: finish mid-stall, then reset mid-flight ----
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst2");
    dut.IM.memory[1] = 32'h20090003; // $t1 = 3, so $t2 = 8
    tick(1);
    reset_n = 1'b1;
    tick(6); // E6: stall pending
    finish = 1'b1;
    tick(5);
    check("fz_pc", dut.pc, 32'h18);
    check("fz_fetch", dut.OutInstruction, 32'h0800000A);
    check("fz_mw", {31'd0, dut.outMW}, 32'h1);
    check("fz_sw_data", dut.outReadData2, 32'd8);
    check("fz_route", dut.MemRoute, 32'd8);
    check("fz_t2_old", dut.RF.Registers[10], 32'd12);
    check("fz_dm3_old", {24'd0, dut.DM.memory[3]}, 32'h0C);
    finish = 1'b0;
    tick(1); // logical E7
    check("rs_pc_hold", dut.pc, 32'h18);
    check("rs_t2", dut.RF.Registers[10], 32'd8);
    check("rs_dm3", {24'd0, dut.DM.memory[3]}, 32'h08);
    check("rs_lw_data", dut.DataMemoryOut, 32'd8);
    tick(1); // E8
    check("rs_pc_e8", dut.pc, 32'h1C);
    tick(1); // E9: lw committed, add $t4 in MEM
    check("rs_t3", dut.RF.Registers[11], 32'd8);
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst3");
    tick(3);
    check("abort_t4", dut.RF.Registers[12], 32'd24);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_pc", dut.pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
